// File: rtl/truth_table_prober.sv
// Purpose: on-chip BIST prober; sweeps all 2**N_IN input vectors of an external function and checks its truth table against REF.
// Latency: busy for 2**N_IN*SETTLE cycles after an accepted start, then a one-cycle done pulse with results.
// Backpressure: none; start is accepted only in IDLE, and start seen in RUN or FIN is dropped, not queued.
module truth_table_prober #(
    parameter int N_IN   = 5,
    parameter int SETTLE = 1,
    parameter logic [2**N_IN-1:0] REF = 32'hD5BA8AE9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      fn_in,
    input  logic                 fn_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   tbl,
    output logic [2**N_IN-1:0]   err_mask,
    output logic [N_IN:0]        err_cnt,
    output logic                 pass
);

    localparam int TBL_W = 2**N_IN;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [N_IN-1:0]  fn_in_q,    fn_in_d;
    logic [CNT_W-1:0] settle_q,   settle_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic [TBL_W-1:0] tbl_q,      tbl_d;
    logic [TBL_W-1:0] err_mask_q, err_mask_d;
    logic [N_IN:0]    err_cnt_q,  err_cnt_d;
    logic             pass_q,     pass_d;

    // Table position of the current vector: entry i lives at bit TBL_W-1-i, which is ~i in N_IN bits.
    logic [N_IN-1:0]  idx;
    logic             mism;

    // Next-state logic: sweep sequencing, sampling and result accumulation.
    always_comb begin
        state_d    = state_q;
        fn_in_d    = fn_in_q;
        settle_d   = settle_q;
        tbl_d      = tbl_q;
        err_mask_d = err_mask_q;
        err_cnt_d  = err_cnt_q;
        pass_d     = pass_q;
        idx        = ~fn_in_q;
        mism       = fn_out ^ REF[idx];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    fn_in_d    = '0;
                    settle_d   = '0;
                    tbl_d      = '0;
                    err_mask_d = '0;
                    err_cnt_d  = '0;
                    pass_d     = 1'b0;
                end
            end
            ST_RUN: begin
                if (settle_q == SETTLE_LAST) begin
                    // Vector has been held SETTLE cycles: capture and move on.
                    settle_d        = '0;
                    tbl_d[idx]      = fn_out;
                    err_mask_d[idx] = mism;
                    if (mism) begin
                        err_cnt_d = err_cnt_q + {{N_IN{1'b0}}, 1'b1};
                    end
                    fn_in_d = fn_in_q + {{(N_IN-1){1'b0}}, 1'b1};
                    if (fn_in_q == {N_IN{1'b1}}) begin
                        state_d = ST_FIN;
                    end
                end else begin
                    settle_d = settle_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pass verdict uses the count including the final vector's compare.
        if (state_d == ST_FIN) begin
            pass_d = (err_cnt_d == '0);
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_FIN);
    end

    // State and result registers; reset aborts any sweep and clears results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fn_in_q    <= '0;
            settle_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tbl_q      <= '0;
            err_mask_q <= '0;
            err_cnt_q  <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fn_in_q    <= fn_in_d;
            settle_q   <= settle_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tbl_q      <= tbl_d;
            err_mask_q <= err_mask_d;
            err_cnt_q  <= err_cnt_d;
            pass_q     <= pass_d;
        end
    end

    assign fn_in    = fn_in_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tbl      = tbl_q;
    assign err_mask = err_mask_q;
    assign err_cnt  = err_cnt_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_truth_table_prober.sv
// Purpose: directed bench for truth_table_prober with SETTLE=1 and SETTLE=3 instances and behavioural function models.
// Latency: one sweep is 32 (or 96) busy cycles plus a done cycle.
// Backpressure: n/a; start is driven as pulses or held high.
module tb_truth_table_prober;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start1 = 1'b0;
    logic [4:0]  fn_in1;
    logic        fn_out1;
    logic        busy1, done1, pass1;
    logic [31:0] tbl1, mask1;
    logic [5:0]  cnt1;

    logic        start3 = 1'b0;
    logic [4:0]  fn_in3;
    logic        fn_out3;
    logic        busy3, done3, pass3;
    logic [31:0] tbl3, mask3;
    logic [5:0]  cnt3;

    logic [31:0] ref_v = 32'hD5BA8AE9;
    int          mode = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    truth_table_prober #(.N_IN(5), .SETTLE(1), .REF(32'hD5BA8AE9)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .fn_in(fn_in1), .fn_out(fn_out1),
        .busy(busy1), .done(done1), .tbl(tbl1), .err_mask(mask1), .err_cnt(cnt1), .pass(pass1)
    );

    truth_table_prober #(.N_IN(5), .SETTLE(3), .REF(32'hD5BA8AE9)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .fn_in(fn_in3), .fn_out(fn_out3),
        .busy(busy3), .done(done3), .tbl(tbl3), .err_mask(mask3), .err_cnt(cnt3), .pass(pass3)
    );

    // Function models for the SETTLE=1 instance, selected by mode.
    logic [4:0] ridx1;
    logic       rb1;
    always_comb begin
        ridx1 = ~fn_in1;
        rb1   = ref_v[ridx1];
        case (mode)
            0:       fn_out1 = rb1;
            1:       fn_out1 = 1'b0;
            2:       fn_out1 = ~rb1;
            3:       fn_out1 = rb1 ^ (fn_in1 == 5'd5);
            default: fn_out1 = rb1;
        endcase
    end

    // Ideal function that answers one cycle late, for the SETTLE=3 instance.
    logic [4:0] ridx3;
    logic       late3 = 1'b0;
    assign ridx3   = ~fn_in3;
    assign fn_out3 = late3;
    always_ff @(posedge clk) late3 <= ref_v[ridx3];

    typedef struct {
        int          mode;
        logic [31:0] tbl;
        logic [31:0] mask;
        int          cnt;
        logic        pass;
        int          ign_at;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pulse start on the SETTLE=1 instance and follow the sweep to its done pulse.
    task automatic run1(input int m, input int ign_at, output int busy_cyc, output int done_cnt,
                        output int order_err, output logic pass_at, output logic to);
        int extra;
        mode = m;
        busy_cyc = 0; done_cnt = 0; order_err = 0; pass_at = 1'b0; to = 1'b1; extra = 0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done1) begin
                done_cnt++;
                pass_at = pass1;
                to = 1'b0;
                break;
            end
            if (busy1) begin
                if (fn_in1 != 5'(busy_cyc)) order_err++;
                busy_cyc++;
            end
            start1 = (k == ign_at);
            @(negedge clk);
        end
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done1 || busy1) extra++;
        end
        done_cnt += extra;
    endtask

    initial begin
        int          bc, dc, oe, bc3, oe3;
        logic        pa, to, pa3, to3;
        vec_t        v;

        vecs[0] = '{0, 32'hD5BA8AE9, 32'h00000000,  0, 1'b1, -1};
        vecs[1] = '{1, 32'h00000000, 32'hD5BA8AE9, 18, 1'b0, -1};
        vecs[2] = '{2, 32'h2A457516, 32'hFFFFFFFF, 32, 1'b0, -1};
        vecs[3] = '{3, 32'hD1BA8AE9, 32'h04000000,  1, 1'b0, -1};
        vecs[4] = '{0, 32'hD5BA8AE9, 32'h00000000,  0, 1'b1,  5};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_fn_in", 64'(fn_in1), 64'd0);
        chk("rst_busy_done_pass", 64'({busy1, done1, pass1}), 64'd0);
        chk("rst_tbl_mask_cnt", {tbl1, mask1} | 64'(cnt1), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven full sweeps on the SETTLE=1 instance.
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            run1(v.mode, v.ign_at, bc, dc, oe, pa, to);
            chk($sformatf("v%0d_timeout", i), 64'(to), 64'd0);
            chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'd32);
            chk($sformatf("v%0d_done_once", i), 64'(dc), 64'd1);
            chk($sformatf("v%0d_fn_in_order", i), 64'(oe), 64'd0);
            chk($sformatf("v%0d_pass_at_done", i), 64'(pa), 64'(v.pass));
            chk($sformatf("v%0d_tbl", i), 64'(tbl1), 64'(v.tbl));
            chk($sformatf("v%0d_err_mask", i), 64'(mask1), 64'(v.mask));
            chk($sformatf("v%0d_err_cnt", i), 64'(cnt1), 64'(v.cnt));
            chk($sformatf("v%0d_pass_hold", i), 64'(pass1), 64'(v.pass));
        end

        // SETTLE=3 with a one-cycle-late function model.
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        bc3 = 0; oe3 = 0; pa3 = 1'b0; to3 = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (done3) begin
                pa3 = pass3; to3 = 1'b0;
                break;
            end
            if (busy3) begin
                if (fn_in3 != 5'(bc3 / 3)) oe3++;
                bc3++;
            end
            @(negedge clk);
        end
        chk("s3_timeout", 64'(to3), 64'd0);
        chk("s3_busy_cycles", 64'(bc3), 64'd96);
        chk("s3_fn_in_every_3", 64'(oe3), 64'd0);
        chk("s3_pass_at_done", 64'(pa3), 64'd1);
        chk("s3_tbl", 64'(tbl3), 64'h00000000D5BA8AE9);
        chk("s3_err_cnt", 64'(cnt3), 64'd0);

        // start held high: FIN, one IDLE cycle, then a new sweep.
        mode = 1;
        @(negedge clk); start1 = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done1) begin to = 1'b0; break; end
        end
        chk("held_timeout", 64'(to), 64'd0);
        chk("held_fin_busy", 64'(busy1), 64'd0);
        @(negedge clk);
        chk("held_idle_busy_done", 64'({busy1, done1}), 64'd0);
        mode = 0;
        @(negedge clk);
        chk("held_restart_busy", 64'(busy1), 64'd1);
        chk("held_restart_fn_in", 64'(fn_in1), 64'd0);
        start1 = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done1) begin to = 1'b0; break; end
        end
        chk("held_second_timeout", 64'(to), 64'd0);
        chk("held_second_pass", 64'(pass1), 64'd1);
        chk("held_second_tbl", 64'(tbl1), 64'h00000000D5BA8AE9);

        // Asynchronous reset mid-sweep at vector 10.
        mode = 0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (fn_in1 == 5'd10) begin to = 1'b0; break; end
            @(negedge clk);
        end
        chk("mid_reach_v10", 64'(to), 64'd0);
        chk("mid_partial_tbl", 64'(tbl1[31:22]), 64'(10'b1101010110));
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("arst_fn_in", 64'(fn_in1), 64'd0);
        chk("arst_busy_done_pass", 64'({busy1, done1, pass1}), 64'd0);
        chk("arst_tbl_mask_cnt", {tbl1, mask1} | 64'(cnt1), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        run1(0, -1, bc, dc, oe, pa, to);
        chk("post_rst_timeout", 64'(to), 64'd0);
        chk("post_rst_busy_cycles", 64'(bc), 64'd32);
        chk("post_rst_done_once", 64'(dc), 64'd1);
        chk("post_rst_tbl", 64'(tbl1), 64'h00000000D5BA8AE9);
        chk("post_rst_mask_cnt_pass", {mask1, 25'd0, cnt1, pass1}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
